// File: rtl/sram_arbiter_if.sv
// Requester handshakes and SRAM pin-level signals for sram_arbiter.
// The arbiter uses the slave modport; the requesters and pads use master.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;

  logic              clr_start;
  logic [DATA_W-1:0] clr_data;
  logic              clr_busy;
  logic              clr_done;

  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic [DATA_W-1:0] sram_dq_out;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_in;

  modport slave (
    input  rd_req, rd_addr,
    output rd_gnt, rd_valid, rd_data,
    input  wr_req, wr_addr, wr_data,
    output wr_gnt,
    input  clr_start, clr_data,
    output clr_busy, clr_done,
    output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
    output sram_dq_out, sram_dq_oe,
    input  sram_dq_in
  );

  modport master (
    output rd_req, rd_addr,
    input  rd_gnt, rd_valid, rd_data,
    output wr_req, wr_addr, wr_data,
    input  wr_gnt,
    output clr_start, clr_data,
    input  clr_busy, clr_done,
    input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
    input  sram_dq_out, sram_dq_oe,
    output sram_dq_in
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one async 16-bit SRAM between VGA reads, program writes and a background fill engine.
// Reads take 2 cycles, writes 3; grants are issued combinationally in IDLE/R2/W3 slots.
module sram_arbiter #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAME_W  = 640,
  parameter int unsigned FRAME_H  = 480,
  parameter int unsigned RD_BURST = 8
) (
  input logic           clk,
  input logic           reset_n,
  sram_arbiter_if.slave bus
);
  localparam int unsigned       BurstW   = $clog2(RD_BURST + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(RD_BURST);
  localparam logic [ADDR_W-1:0] FillLast = ADDR_W'(FRAME_W * FRAME_H - 1);

  typedef enum logic [2:0] {StIdle, StR1, StR2, StW1, StW2, StW3} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_fill_q, is_fill_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_color_q, fill_color_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;

  logic              slot;
  logic              rd_win;
  logic              wr_win;
  logic              fill_win;
  logic              fill_w3;
  logic              fill_last;
  logic [ADDR_W-1:0] fill_slot_addr;

  // Arbitration; gated by reset_n so no grant is ever shown while held in reset.
  always_comb begin
    slot = reset_n && ((state_q == StIdle) || (state_q == StR2) || (state_q == StW3));
    fill_w3   = (state_q == StW3) && is_fill_q;
    fill_last = fill_w3 && (fill_addr_q == FillLast);
    // A fill slot won during a fill W3 must target the word after the one just written.
    fill_slot_addr = fill_w3 ? fill_addr_q + ADDR_W'(1) : fill_addr_q;
    wr_win   = slot && bus.wr_req && (!bus.rd_req || (burst_q == BurstMax));
    rd_win   = slot && bus.rd_req && !wr_win;
    fill_win = slot && clr_busy_q && !fill_last && !bus.rd_req && !bus.wr_req;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_fill_d    = is_fill_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    burst_d      = burst_q;
    fill_addr_d  = fill_addr_q;
    fill_color_d = fill_color_q;
    clr_busy_d   = clr_busy_q;
    clr_done_d   = 1'b0;

    case (state_q)
      StR1:    state_d = StR2;
      StW1:    state_d = StW2;
      StW2:    state_d = StW3;
      default: state_d = StIdle;
    endcase

    if (state_q == StR2) begin
      rd_valid_d = 1'b1;
      rd_data_d  = bus.sram_dq_in;
    end

    if (fill_w3) begin
      if (fill_last) begin
        clr_busy_d = 1'b0;
        clr_done_d = 1'b1;
      end else begin
        fill_addr_d = fill_addr_q + ADDR_W'(1);
      end
    end

    if (rd_win) begin
      state_d   = StR1;
      addr_d    = bus.rd_addr;
      is_fill_d = 1'b0;
      if (bus.wr_req && (burst_q != BurstMax)) begin
        burst_d = burst_q + BurstW'(1);
      end
    end else if (wr_win) begin
      state_d   = StW1;
      addr_d    = bus.wr_addr;
      wdata_d   = bus.wr_data;
      is_fill_d = 1'b0;
      burst_d   = '0;
    end else if (fill_win) begin
      state_d   = StW1;
      addr_d    = fill_slot_addr;
      wdata_d   = fill_color_q;
      is_fill_d = 1'b1;
    end

    if (!clr_busy_q && bus.clr_start) begin
      clr_busy_d   = 1'b1;
      fill_addr_d  = '0;
      fill_color_d = bus.clr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_fill_q    <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      burst_q      <= '0;
      fill_addr_q  <= '0;
      fill_color_q <= '0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_fill_q    <= is_fill_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      burst_q      <= burst_d;
      fill_addr_q  <= fill_addr_d;
      fill_color_q <= fill_color_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
    end
  end

  // Pin controls decode straight from state so reset releases the bus immediately.
  always_comb begin
    bus.SRAM_CE_N  = 1'b1;
    bus.SRAM_OE_N  = 1'b1;
    bus.SRAM_WE_N  = 1'b1;
    bus.SRAM_UB_N  = 1'b1;
    bus.SRAM_LB_N  = 1'b1;
    bus.sram_dq_oe = 1'b0;
    case (state_q)
      StR1, StR2: begin
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_OE_N = 1'b0;
        bus.SRAM_UB_N = 1'b0;
        bus.SRAM_LB_N = 1'b0;
      end
      StW1, StW2, StW3: begin
        bus.SRAM_CE_N  = 1'b0;
        bus.SRAM_UB_N  = 1'b0;
        bus.SRAM_LB_N  = 1'b0;
        bus.sram_dq_oe = 1'b1;
        bus.SRAM_WE_N  = (state_q != StW2);
      end
      default: ;
    endcase
  end

  assign bus.SRAM_ADDR   = addr_q;
  assign bus.sram_dq_out = wdata_q;
  assign bus.rd_gnt      = rd_win;
  assign bus.wr_gnt      = wr_win;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.clr_busy    = clr_busy_q;
  assign bus.clr_done    = clr_done_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed timing scenarios plus random read/write traffic,
// checked against a transaction-level memory model and the arbitration rules.
module tb_sram_arbiter;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned FW = 4;
  localparam int unsigned FH = 2;
  localparam int unsigned RB = 8;
  localparam int unsigned FillWords = FW * FH;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FRAME_W(FW), .FRAME_H(FH), .RD_BURST(RB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ctrl_pins();
    return {bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_UB_N, bus.SRAM_LB_N};
  endfunction

  function automatic logic [DW-1:0] bg_word(input logic [AW-1:0] a);
    logic [DW-1:0] lo;
    lo = a[DW-1:0];
    return lo ^ 16'hC3A5;
  endfunction

  // Pin-level SRAM: contents seen through the pads.
  logic [DW-1:0] pin_mem [logic [AW-1:0]];
  // Reference contents: updated from accepted write transactions only.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] pin_rd(input logic [AW-1:0] a);
    return pin_mem.exists(a) ? pin_mem[a] : bg_word(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg_word(a);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } we_t;
  we_t we_log[$];

  always @(negedge clk) begin
    if (!bus.SRAM_CE_N && !bus.SRAM_WE_N && bus.sram_dq_oe) begin
      pin_mem[bus.SRAM_ADDR] = bus.sram_dq_out;
      we_log.push_back('{bus.SRAM_ADDR, bus.sram_dq_out, cyc});
    end
    bus.sram_dq_in = (!bus.SRAM_CE_N && !bus.SRAM_OE_N) ? pin_rd(bus.SRAM_ADDR) : '0;
  end

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;
  rd_exp_t rd_q[$];
  bit      gnt_log[$];
  int      last_gnt_cyc = -100;
  bit      last_was_wr = 1'b0;
  int      pend_reads = 0;
  int      done_pulses = 0;
  int      done_cyc = 0;
  int      valid_cnt = 0;

  always @(negedge clk) begin
    rd_exp_t e;
    if (!reset_n) begin
      rd_q.delete();
      pend_reads   = 0;
      last_gnt_cyc = -100;
    end else begin
      if (bus.rd_gnt || bus.wr_gnt) begin
        check_eq("one_grant", 32'(bus.rd_gnt & bus.wr_gnt), 32'd0);
        check_eq("grant_spacing", 32'((cyc - last_gnt_cyc) >= (last_was_wr ? 3 : 2)), 32'd1);
        last_gnt_cyc = cyc;
        last_was_wr  = bus.wr_gnt;
      end
      if (bus.rd_gnt) begin
        rd_q.push_back('{ref_rd(bus.rd_addr), cyc + 3});
        gnt_log.push_back(1'b0);
        if (bus.wr_req) begin
          pend_reads++;
          check_eq("write_starved", 32'(pend_reads <= RB), 32'd1);
        end
      end
      if (bus.wr_gnt) begin
        ref_mem[bus.wr_addr] = bus.wr_data;
        gnt_log.push_back(1'b1);
        if (bus.rd_req) check_eq("write_over_read", 32'(pend_reads), 32'(RB));
        pend_reads = 0;
      end
      if (bus.rd_valid) begin
        valid_cnt++;
        if (rd_q.size() == 0) begin
          check_eq("rd_valid_spurious", 32'(rd_q.size()), 32'd1);
        end else begin
          e = rd_q.pop_front();
          check_eq("rd_data", 32'(bus.rd_data), 32'(e.data));
          check_eq("rd_latency", 32'(cyc), 32'(e.due));
        end
      end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
        check_eq("rd_valid_missing", 32'(bus.rd_valid), 32'd1);
        void'(rd_q.pop_front());
      end
      if (bus.clr_done) begin
        done_pulses++;
        done_cyc = cyc;
      end
    end
  end

  task automatic rd_client(input int n);
    for (int i = 0; i < n; i++) begin
      int waited;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      bus.rd_req  = 1'b1;
      bus.rd_addr = 20'h200 + 20'($urandom_range(0, 31));
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!bus.rd_gnt && waited < 64);
      if (!bus.rd_gnt) check_eq("rd_timeout", 32'(bus.rd_gnt), 32'd1);
      @(posedge clk);
      #1;
      bus.rd_req = 1'b0;
    end
  endtask

  task automatic wr_client(input int n);
    for (int i = 0; i < n; i++) begin
      int waited;
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 20'h200 + 20'($urandom_range(0, 31));
      bus.wr_data = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        // Request withdrawn after one cycle, granted or not.
        @(posedge clk);
        #1;
        bus.wr_req = 1'b0;
      end else begin
        waited = 0;
        do begin
          @(negedge clk);
          waited++;
        end while (!bus.wr_gnt && waited < 64);
        if (!bus.wr_gnt) check_eq("wr_timeout", 32'(bus.wr_gnt), 32'd1);
        @(posedge clk);
        #1;
        bus.wr_req = 1'b0;
      end
    end
  endtask

  task automatic pulse_clr(input logic [DW-1:0] color);
    @(posedge clk);
    #1;
    bus.clr_start = 1'b1;
    bus.clr_data  = color;
    @(posedge clk);
    #1;
    bus.clr_start = 1'b0;
    bus.clr_data  = 16'hFFFF;
  endtask

  task automatic wait_done(input string tag);
    int waited = 0;
    while (bus.clr_done !== 1'b1 && waited < 80) begin
      @(negedge clk);
      waited++;
    end
    check_eq(tag, 32'(bus.clr_done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int lead;
    bus.rd_req    = 1'b1;
    bus.rd_addr   = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_start = 1'b0;
    bus.clr_data  = '0;
    reset_n       = 1'b0;

    // Reset state, with a read request pending that must not be granted.
    repeat (3) @(negedge clk);
    check_eq("rst_addr", 32'(bus.SRAM_ADDR), 32'd0);
    check_eq("rst_ctrl", 32'(ctrl_pins()), 32'h1F);
    check_eq("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    check_eq("rst_dq_out", 32'(bus.sram_dq_out), 32'd0);
    check_eq("rst_gnts", 32'({bus.rd_gnt, bus.wr_gnt}), 32'd0);
    check_eq("rst_rd", 32'({bus.rd_valid, bus.rd_data}), 32'd0);
    check_eq("rst_clr", 32'({bus.clr_busy, bus.clr_done}), 32'd0);
    bus.rd_req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single read.
    pin_mem[20'h00064] = 16'hABCD;
    ref_mem[20'h00064] = 16'hABCD;
    @(posedge clk);
    #1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 20'h00064;
    @(negedge clk);
    check_eq("rd_gnt_c0", 32'(bus.rd_gnt), 32'd1);
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check_eq("rd_pins_c12", 32'({ctrl_pins(), bus.sram_dq_oe}), 32'({5'b00100, 1'b0}));
      check_eq("rd_addr_c12", 32'(bus.SRAM_ADDR), 32'h00064);
    end
    @(negedge clk);
    check_eq("rd_valid_c3", 32'(bus.rd_valid), 32'd1);
    check_eq("rd_data_c3", 32'(bus.rd_data), 32'hABCD);
    @(negedge clk);
    check_eq("rd_valid_c4", 32'(bus.rd_valid), 32'd0);

    // Single write.
    @(posedge clk);
    #1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 20'h1F4C8;
    bus.wr_data = 16'h0000;
    @(negedge clk);
    check_eq("wr_gnt_c0", 32'(bus.wr_gnt), 32'd1);
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_eq("wr_we_n", 32'(bus.SRAM_WE_N), (c == 2) ? 32'd0 : 32'd1);
      check_eq("wr_pins", 32'({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.sram_dq_oe}), 32'b011);
      check_eq("wr_addr_stable", 32'(bus.SRAM_ADDR), 32'h1F4C8);
      check_eq("wr_data", 32'(bus.sram_dq_out), 32'h0000);
    end
    @(negedge clk);
    check_eq("wr_idle_c4", 32'({ctrl_pins(), bus.sram_dq_oe}), 32'({5'h1F, 1'b0}));
    check_eq("wr_addr_hold", 32'(bus.SRAM_ADDR), 32'h1F4C8);

    // Read held high against a pending write: exactly RB reads, then the write.
    gnt_log.delete();
    @(posedge clk);
    #1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 20'h1F4C8;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 20'h00300;
    bus.wr_data = 16'h5A5A;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.wr_gnt && waited < 60);
    check_eq("burst_wr_gnt", 32'(bus.wr_gnt), 32'd1);
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    waited = 0;
    while (gnt_log.size() < RB + 3 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    lead = 0;
    while (lead < gnt_log.size() && !gnt_log[lead]) lead++;
    check_eq("burst_reads", 32'(lead), 32'(RB));
    check_eq("burst_then_wr", 32'(gnt_log.size() > RB + 1 && gnt_log[RB] && !gnt_log[RB + 1]),
             32'd1);

    // Background fill, with a second start mid-fill that must be ignored.
    repeat (5) @(negedge clk);
    we_log.delete();
    done_pulses = 0;
    pulse_clr(16'h001F);
    @(negedge clk);
    check_eq("fill_busy", 32'(bus.clr_busy), 32'd1);
    repeat (6) @(negedge clk);
    pulse_clr(16'hFFFF);
    wait_done("fill_done_seen");
    repeat (4) @(negedge clk);
    check_eq("fill_done_once", 32'(done_pulses), 32'd1);
    check_eq("fill_busy_after", 32'(bus.clr_busy), 32'd0);
    check_eq("fill_words", 32'(we_log.size()), 32'(FillWords));
    for (int i = 0; i < we_log.size(); i++) begin
      check_eq("fill_addr", 32'(we_log[i].addr), 32'(i));
      check_eq("fill_color", 32'(we_log[i].data), 32'h001F);
      if (i > 0) check_eq("fill_pitch", 32'(we_log[i].cyc - we_log[i-1].cyc), 32'd3);
    end
    if (we_log.size() != 0) begin
      check_eq("fill_done_timing", 32'(done_cyc), 32'(we_log[we_log.size()-1].cyc + 2));
    end

    // Read preempting a fill: granted at the next slot, fill resumes without a gap.
    we_log.delete();
    done_pulses = 0;
    pulse_clr(16'h07E0);
    waited = 0;
    while (we_log.size() < 3 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 20'h00100;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.rd_gnt && waited < 20);
    check_eq("preempt_next_slot", 32'(bus.rd_gnt && waited <= 3), 32'd1);
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    wait_done("preempt_done_seen");
    repeat (3) @(negedge clk);
    check_eq("preempt_words", 32'(we_log.size()), 32'(FillWords));
    for (int i = 0; i < we_log.size(); i++) begin
      check_eq("preempt_addr", 32'(we_log[i].addr), 32'(i));
      check_eq("preempt_color", 32'(we_log[i].data), 32'h07E0);
    end

    // Random concurrent read/write traffic.
    @(posedge clk);
    #1;
    fork
      rd_client(60);
      wr_client(40);
    join
    repeat (8) @(negedge clk);
    check_eq("rand_drain", 32'(rd_q.size()), 32'd0);

    // Reset asserted during the WE pulse of a fill write.
    done_pulses = 0;
    pulse_clr(16'h1234);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.SRAM_WE_N && waited < 20);
    check_eq("rstw_in_w2", 32'(bus.SRAM_WE_N), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rstw_pins", 32'({bus.SRAM_WE_N, bus.SRAM_CE_N, bus.sram_dq_oe}), 32'b110);
    check_eq("rstw_busy", 32'(bus.clr_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("rstw_no_done", 32'(done_pulses), 32'd0);
    check_eq("rstw_idle", 32'({ctrl_pins(), bus.sram_dq_oe}), 32'({5'h1F, 1'b0}));

    // Reset asserted during R2 of a read: its data must never be delivered.
    @(posedge clk);
    #1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 20'h00210;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.rd_gnt && waited < 20);
    check_eq("rstr_gnt", 32'(bus.rd_gnt), 32'd1);
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rstr_oe", 32'(bus.SRAM_OE_N), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    valid_cnt = 0;
    repeat (8) @(negedge clk);
    check_eq("rstr_no_valid", 32'(valid_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
